dispatch_ex_skid: RTL and testbench
===================================

Name: dispatch_ex_skid

Overview:
- Parametrised, multi-lane elastic pipeline register between dispatch and execute.
- Replaces the single-entry pause-driven register with a valid/ready handshake.
- Adds a one-bundle skid entry so `in_ready` is registered, plus full exception flush, per-lane kill of the issuing bundle, and a saturating stall-cycle counter.

Parameters:
- LANES, 2, issue lanes per bundle (1..4).
- DATA_W, 128, payload bits per lane.
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  LANES  per-lane valid from dispatch
- in_data  in  LANES*DATA_W  lane payloads, lane 0 in LSBs
- in_ready  out  1  bundle accepted when high
- out_valid  out  LANES  per-lane valid to execute
- out_data  out  LANES*DATA_W  lane payloads
- out_ready  in  1  execute consumes the bundle when high
- exception_flush  in  1  clear all held state
- kill_valid  in  1  apply kill_mask this cycle
- kill_mask  in  LANES  lanes of the main entry to invalidate
- occupancy  out  2  held bundles: 0, 1 or 2
- stall_cycles  out  CNT_W  saturating count of blocked cycles

Behaviour:
- Reset is asynchronous, active-high and clocked on clk; rst asserts immediately, independent of clk. On reset:
  - main and skid valid bits = 0; payload registers = 0.
  - out_valid = 0, out_data = 0, in_ready = 1, occupancy = 0, stall_cycles = 0.
  - Reset mid-transfer discards both entries; there is no partial state.
- Storage: a main entry drives out_*; a skid entry holds one further bundle. Each entry is LANES valid bits plus payload.
- Entry valid means at least one lane valid bit is 1.
- Derived signals:
  - in_fire = |in_valid & in_ready.
  - An all-zero in_valid is a bubble: never stored, never counted.
  - out_fire = |out_valid & out_ready.
- in_ready is registered: in_ready = !skid_valid. No combinational path from out_ready to in_ready.
- Latency: an accepted bundle appears on out_* the next cycle when main is empty or firing; otherwise it waits in skid.
- Update priority each cycle:
  1. exception_flush: both entries are cleared next cycle, the input that cycle is dropped even if in_fire, kill is ignored, and in_ready = 1 next cycle. Payloads may hold stale data; valid bits are authoritative.
  2. Otherwise, kill:
     - If kill_valid && !out_fire, main lane valids &= ~kill_mask.
     - If out_fire, kill is ignored because the bundle was consumed that cycle.
     - Kill never touches skid.
  3. Main refill. When main is empty, firing, or emptied by kill this cycle:
     - main <= skid if skid is valid, and skid is cleared.
     - Else main <= input if in_fire.
     - Else main is cleared.
  4. Skid fill. When main is held (valid, not firing, not fully killed) and in_fire, skid <= input. Skid-full plus in_fire cannot occur (in_ready = 0).
  5. Simultaneous out_fire and in_fire with skid empty: the input goes straight to main, occupancy stays 1, and there is no bubble.
- Ordering: bundles leave in acceptance order; lanes are never reordered or compacted. Killed lanes still occupy their positions and their payload is passed unchanged.
- occupancy = main_valid + skid_valid.
- stall_cycles:
  - Increments when main is valid && !out_ready.
  - Saturates at 2^CNT_W-1.
  - Unaffected by exception_flush; cleared only by rst.
- out_data is stable while out_valid is nonzero and out_ready is low; the only change permitted is kill clearing lanes.

Test Plan:
- Streaming: LANES=2, in_valid=2'b11 on every cycle, out_ready=1 on every cycle, payloads 1,2,3 → out_* shows 1,2,3 on consecutive cycles one cycle later; occupancy stays 1; in_ready stays 1.
- Backpressure: out_ready=0 while bundles A,B,C are presented → A in main, B in skid, in_ready=0 from the cycle after B, C held upstream, occupancy=2. Raise out_ready → A, B, C emerge in order with no loss or duplication.
- Bubble: in_valid=2'b00 for 3 cycles amid traffic → nothing stored; occupancy never counts a bubble; out_valid=0 in those slots.
- Flush: occupancy=2, then exception_flush together with a valid input D → next cycle out_valid=0, occupancy=0, in_ready=1, D absent; stall_cycles keeps its value.
- Kill: main={lane0,lane1} valid, out_ready=0, kill_mask=2'b10 → out_valid=2'b01 next cycle. Repeat with kill_mask=2'b11 while skid is valid → skid bundle moves to main next cycle. Kill with out_fire=1 → no effect.
- Counter/reset: out_ready=0 with main valid for 5 cycles → stall_cycles=5. With CNT_W=3 and 10 blocked cycles → value 7. Assert rst between clock edges → all outputs hit reset values immediately.

Source files
------------

// File: rtl/dispatch_ex_skid.sv
// Elastic multi-lane pipeline register between dispatch and execute.
// A main entry drives execute; a skid entry absorbs one extra bundle so in_ready comes from a flop.
module dispatch_ex_skid #(
  parameter int LANES  = 2,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES-1:0]        in_valid,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    in_ready,
  output logic [LANES-1:0]        out_valid,
  output logic [LANES*DATA_W-1:0] out_data,
  input  logic                    out_ready,
  input  logic                    exception_flush,
  input  logic                    kill_valid,
  input  logic [LANES-1:0]        kill_mask,
  output logic [1:0]              occupancy,
  output logic [CNT_W-1:0]        stall_cycles
);

  logic [LANES-1:0]        r_mainValid;
  logic [LANES*DATA_W-1:0] r_mainData;
  logic [LANES-1:0]        r_skidValid;
  logic [LANES*DATA_W-1:0] r_skidData;
  logic [CNT_W-1:0]        r_stallCnt;

  logic             w_mainV;
  logic             w_skidV;
  logic             w_inFire;
  logic             w_outFire;
  logic [LANES-1:0] w_keptValid;
  logic             w_mainFree;
  logic             w_stallMax;

  assign w_mainV   = |r_mainValid;
  assign w_skidV   = |r_skidValid;
  assign in_ready  = ~w_skidV;
  assign w_inFire  = (|in_valid) & in_ready;
  assign w_outFire = w_mainV & out_ready;

  // A consumed bundle cannot be killed; a fully killed main frees its slot this cycle.
  assign w_keptValid = (kill_valid && !w_outFire) ? (r_mainValid & ~kill_mask) : r_mainValid;
  assign w_mainFree  = w_outFire | ~(|w_keptValid);
  assign w_stallMax  = &r_stallCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mainValid <= '0;
      r_mainData  <= '0;
      r_skidValid <= '0;
      r_skidData  <= '0;
    end else if (exception_flush) begin
      r_mainValid <= '0;
      r_skidValid <= '0;
    end else if (w_mainFree) begin
      // in_ready is low whenever skid holds a bundle, so skid and input never compete here.
      if (w_skidV) begin
        r_mainValid <= r_skidValid;
        r_mainData  <= r_skidData;
        r_skidValid <= '0;
      end else if (w_inFire) begin
        r_mainValid <= in_valid;
        r_mainData  <= in_data;
      end else begin
        r_mainValid <= '0;
      end
    end else begin
      r_mainValid <= w_keptValid;
      if (w_inFire) begin
        r_skidValid <= in_valid;
        r_skidData  <= in_data;
      end
    end
  end

  // Blocked-cycle counter survives exception flushes; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stallCnt <= '0;
    end else if (w_mainV && !out_ready && !w_stallMax) begin
      r_stallCnt <= r_stallCnt + 1'b1;
    end
  end

  assign out_valid    = r_mainValid;
  assign out_data     = r_mainData;
  assign occupancy    = {1'b0, w_mainV} + {1'b0, w_skidV};
  assign stall_cycles = r_stallCnt;

endmodule

// File: tb/tb_dispatch_ex_skid.sv
// Self-checking bench for dispatch_ex_skid: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_dispatch_ex_skid;

  localparam int LANES  = 2;
  localparam int DATA_W = 16;
  localparam int BUS    = LANES * DATA_W;
  localparam int NVEC   = 25;
  localparam int NRAND  = 3000;
  localparam longint SATMAX = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic [LANES-1:0] inValid;
  logic [BUS-1:0]   inData;
  logic             outReady;
  logic             flush;
  logic             killValid;
  logic [LANES-1:0] killMask;

  logic             inReady;
  logic [LANES-1:0] outValid;
  logic [BUS-1:0]   outData;
  logic [1:0]       occupancy;
  logic [31:0]      stallCycles;

  logic             inReadySat;
  logic [LANES-1:0] outValidSat;
  logic [BUS-1:0]   outDataSat;
  logic [1:0]       occupancySat;
  logic [2:0]       stallCyclesSat;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [1:0]  inV;
    logic [31:0] inD;
    logic        oR;
    logic        fl;
    logic        kv;
    logic [1:0]  km;
    logic [1:0]  expV;
    logic [31:0] expD;
    int          expOcc;
    logic        expRdy;
    longint      expStall;
  } vec_t;

  typedef struct {
    logic [1:0]  v;
    logic [31:0] d;
  } bundle_t;

  vec_t    vecs[NVEC];
  bundle_t q[$];
  longint  stallModel;

  dispatch_ex_skid #(.LANES(LANES), .DATA_W(DATA_W), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(inValid), .in_data(inData), .in_ready(inReady),
    .out_valid(outValid), .out_data(outData), .out_ready(outReady),
    .exception_flush(flush), .kill_valid(killValid), .kill_mask(killMask),
    .occupancy(occupancy), .stall_cycles(stallCycles)
  );

  dispatch_ex_skid #(.LANES(LANES), .DATA_W(DATA_W), .CNT_W(3)) dutSat (
    .clk(clk), .rst(rst),
    .in_valid(inValid), .in_data(inData), .in_ready(inReadySat),
    .out_valid(outValidSat), .out_data(outDataSat), .out_ready(outReady),
    .exception_flush(flush), .kill_valid(killValid), .kill_mask(killMask),
    .occupancy(occupancySat), .stall_cycles(stallCyclesSat)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkVec(logic [1:0] inV, logic [31:0] inD, logic oR, logic fl,
                                 logic kv, logic [1:0] km, logic [1:0] expV,
                                 logic [31:0] expD, int expOcc, logic expRdy,
                                 longint expStall);
    vec_t v;
    v.inV = inV; v.inD = inD; v.oR = oR; v.fl = fl; v.kv = kv; v.km = km;
    v.expV = expV; v.expD = expD; v.expOcc = expOcc; v.expRdy = expRdy;
    v.expStall = expStall;
    return v;
  endfunction

  task automatic cmp(input string nm, input longint got, input longint want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, want %0h", nm, got, want);
    end
  endtask

  // Drive one cycle of inputs, then step to just past the next rising edge.
  task automatic applyStimulus(input logic [1:0] inV, input logic [31:0] inD, input logic oR,
                               input logic fl, input logic kv, input logic [1:0] km);
    inValid   = inV;
    inData    = inD;
    outReady  = oR;
    flush     = fl;
    killValid = kv;
    killMask  = km;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string label, input logic [1:0] expV, input logic [31:0] expD,
                             input int expOcc, input logic expRdy, input longint expStall);
    longint satWant;
    satWant = (expStall > SATMAX) ? SATMAX : expStall;
    cmp({label, ".outValid"}, longint'(outValid), longint'(expV));
    if (expV != 2'b00) cmp({label, ".outData"}, longint'(outData), longint'(expD));
    cmp({label, ".occupancy"}, longint'(occupancy), longint'(expOcc));
    cmp({label, ".inReady"}, longint'(inReady), longint'(expRdy));
    cmp({label, ".stallCycles"}, longint'(stallCycles), expStall);
    cmp({label, ".stallSat"}, longint'(stallCyclesSat), satWant);
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    applyStimulus(2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00);
    rst = 1'b0;
  endtask

  initial begin
    // Streaming, bubbles, backpressure, flush, kill, partial lanes, saturation.
    vecs[0]  = mkVec(2'b11, 32'h00010001, 1, 0, 0, 2'b00, 2'b11, 32'h00010001, 1, 1, 0);
    vecs[1]  = mkVec(2'b11, 32'h00020002, 1, 0, 0, 2'b00, 2'b11, 32'h00020002, 1, 1, 0);
    vecs[2]  = mkVec(2'b11, 32'h00030003, 1, 0, 0, 2'b00, 2'b11, 32'h00030003, 1, 1, 0);
    vecs[3]  = mkVec(2'b00, 32'hDEAD0001, 1, 0, 0, 2'b00, 2'b00, 32'h0,        0, 1, 0);
    vecs[4]  = mkVec(2'b00, 32'hDEAD0002, 1, 0, 0, 2'b00, 2'b00, 32'h0,        0, 1, 0);
    vecs[5]  = mkVec(2'b00, 32'hDEAD0003, 1, 0, 0, 2'b00, 2'b00, 32'h0,        0, 1, 0);
    vecs[6]  = mkVec(2'b11, 32'h000A000A, 0, 0, 0, 2'b00, 2'b11, 32'h000A000A, 1, 1, 0);
    vecs[7]  = mkVec(2'b11, 32'h000B000B, 0, 0, 0, 2'b00, 2'b11, 32'h000A000A, 2, 0, 1);
    vecs[8]  = mkVec(2'b11, 32'h000C000C, 0, 0, 0, 2'b00, 2'b11, 32'h000A000A, 2, 0, 2);
    vecs[9]  = mkVec(2'b11, 32'h000C000C, 1, 0, 0, 2'b00, 2'b11, 32'h000B000B, 1, 1, 2);
    vecs[10] = mkVec(2'b11, 32'h000C000C, 1, 0, 0, 2'b00, 2'b11, 32'h000C000C, 1, 1, 2);
    vecs[11] = mkVec(2'b00, 32'h0,        1, 0, 0, 2'b00, 2'b00, 32'h0,        0, 1, 2);
    vecs[12] = mkVec(2'b11, 32'h000E000E, 0, 0, 0, 2'b00, 2'b11, 32'h000E000E, 1, 1, 2);
    vecs[13] = mkVec(2'b11, 32'h000F000F, 0, 0, 0, 2'b00, 2'b11, 32'h000E000E, 2, 0, 3);
    vecs[14] = mkVec(2'b11, 32'h000D000D, 0, 1, 0, 2'b00, 2'b00, 32'h0,        0, 1, 4);
    vecs[15] = mkVec(2'b11, 32'h00110011, 0, 0, 0, 2'b00, 2'b11, 32'h00110011, 1, 1, 4);
    vecs[16] = mkVec(2'b00, 32'h0,        0, 0, 1, 2'b10, 2'b01, 32'h00110011, 1, 1, 5);
    vecs[17] = mkVec(2'b11, 32'h00120012, 0, 0, 0, 2'b00, 2'b01, 32'h00110011, 2, 0, 6);
    vecs[18] = mkVec(2'b00, 32'h0,        0, 0, 1, 2'b11, 2'b11, 32'h00120012, 1, 1, 7);
    vecs[19] = mkVec(2'b11, 32'h00130013, 1, 0, 1, 2'b11, 2'b11, 32'h00130013, 1, 1, 7);
    vecs[20] = mkVec(2'b00, 32'h0,        1, 0, 0, 2'b00, 2'b00, 32'h0,        0, 1, 7);
    vecs[21] = mkVec(2'b01, 32'h00140014, 0, 0, 0, 2'b00, 2'b01, 32'h00140014, 1, 1, 7);
    vecs[22] = mkVec(2'b10, 32'h00150015, 0, 0, 0, 2'b00, 2'b01, 32'h00140014, 2, 0, 8);
    vecs[23] = mkVec(2'b00, 32'h0,        1, 0, 0, 2'b00, 2'b10, 32'h00150015, 1, 1, 8);
    vecs[24] = mkVec(2'b00, 32'h0,        1, 0, 0, 2'b00, 2'b00, 32'h0,        0, 1, 8);

    inValid = '0; inData = '0; outReady = 1'b0; flush = 1'b0; killValid = 1'b0; killMask = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset", 2'b00, 32'h0, 0, 1'b1, 0);
    cmp("reset.outData", longint'(outData), 0);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].inV, vecs[i].inD, vecs[i].oR, vecs[i].fl, vecs[i].kv, vecs[i].km);
      checkOutput($sformatf("vec%0d", i), vecs[i].expV, vecs[i].expD, vecs[i].expOcc,
                  vecs[i].expRdy, vecs[i].expStall);
    end

    // Reset asserted between edges must clear everything without waiting for a clock.
    applyStimulus(2'b11, 32'h00210021, 0, 0, 0, 2'b00);
    applyStimulus(2'b11, 32'h00220022, 0, 0, 0, 2'b00);
    checkOutput("preAsyncReset", 2'b11, 32'h00210021, 2, 1'b0, 9);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncReset", 2'b00, 32'h0, 0, 1'b1, 0);
    cmp("asyncReset.outData", longint'(outData), 0);
    applyStimulus(2'b00, 32'h0, 0, 0, 0, 2'b00);
    rst = 1'b0;

    // Stall counter: five blocked cycles, then five more to push the 3-bit copy past its ceiling.
    applyStimulus(2'b11, 32'h00310031, 0, 0, 0, 2'b00);
    checkOutput("cntLoad", 2'b11, 32'h00310031, 1, 1'b1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(2'b00, 32'h0, 0, 0, 0, 2'b00);
    checkOutput("cnt5", 2'b11, 32'h00310031, 1, 1'b1, 5);
    for (int i = 0; i < 5; i++) applyStimulus(2'b00, 32'h0, 0, 0, 0, 2'b00);
    checkOutput("cnt10", 2'b11, 32'h00310031, 1, 1'b1, 10);

    // Randomized traffic against a FIFO-of-bundles model.
    pulseReset();
    q.delete();
    stallModel = 0;
    for (int n = 0; n < NRAND; n++) begin
      logic [1:0]  rV;
      logic [31:0] rD;
      logic        rOR, rFl, rKv;
      logic [1:0]  rKm;
      logic        inFireM, outFireM;
      bundle_t     b;
      logic [1:0]  eV;
      logic [31:0] eD;

      rV  = 2'($urandom_range(0, 3));
      rD  = $urandom;
      rOR = ($urandom_range(0, 9) < 6);
      rFl = ($urandom_range(0, 39) == 0);
      rKv = ($urandom_range(0, 5) == 0);
      rKm = 2'($urandom_range(0, 3));

      if (q.size() > 0 && !rOR && stallModel < 64'hFFFF_FFFF) stallModel++;
      if (rFl) begin
        q.delete();
      end else begin
        inFireM  = (rV != 2'b00) && (q.size() < 2);
        outFireM = (q.size() > 0) && rOR;
        if (outFireM) begin
          void'(q.pop_front());
        end else if (q.size() > 0 && rKv) begin
          b = q[0];
          b.v = b.v & ~rKm;
          if (b.v == 2'b00) void'(q.pop_front());
          else q[0] = b;
        end
        if (inFireM) begin
          b.v = rV;
          b.d = rD;
          q.push_back(b);
        end
      end

      applyStimulus(rV, rD, rOR, rFl, rKv, rKm);
      eV = (q.size() > 0) ? q[0].v : 2'b00;
      eD = (q.size() > 0) ? q[0].d : 32'h0;
      checkOutput($sformatf("rand%0d", n), eV, eD, q.size(), (q.size() < 2), stallModel);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
